// File: rtl/lc3_mem_responder.sv
// Dual-port 16-bit word memory for the LC3 pipeline. The fetch and data ports each have
// a fixed number of wait states and a one-cycle completion strobe.
module lc3_mem_responder #(
  parameter int unsigned AW      = 16,
  parameter int unsigned T_FETCH = 0,
  parameter int unsigned T_DATA  = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] pc,
  input  logic        instrmem_rd,
  output logic [15:0] Instr_dout,
  output logic        complete_instr,
  input  logic        data_req,
  input  logic        Data_rd,
  input  logic [15:0] Data_addr,
  input  logic [15:0] Data_din,
  output logic [15:0] Data_dout,
  output logic        complete_data,
  input  logic        load_en,
  input  logic [15:0] load_addr,
  input  logic [15:0] load_data
);

  localparam int unsigned Depth      = 2 ** AW;
  localparam logic [3:0]  FetchWaits = 4'(T_FETCH);
  localparam logic [3:0]  DataWaits  = 4'(T_DATA);

  typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

  logic [15:0] mem [Depth];

  // Instruction port
  state_e          i_state_q, i_state_d;
  logic [3:0]      i_cnt_q, i_cnt_d;
  logic [AW-1:0]   i_addr_q;
  logic            i_capture, i_access;
  logic [AW-1:0]   i_addr;
  logic [15:0]     instr_q;
  logic            complete_instr_q;

  // Data port
  state_e          d_state_q, d_state_d;
  logic [3:0]      d_cnt_q, d_cnt_d;
  logic [AW-1:0]   d_addr_q;
  logic            d_rd_q;
  logic [15:0]     d_din_q;
  logic            d_capture, d_access;
  logic [AW-1:0]   d_addr;
  logic            d_rd;
  logic [15:0]     d_din;
  logic [15:0]     data_q;
  logic            complete_data_q;

  // With zero wait states the access happens on the capture edge, so IDLE uses live inputs.
  assign i_addr = (i_state_q == StIdle) ? pc[AW-1:0] : i_addr_q;
  assign d_addr = (d_state_q == StIdle) ? Data_addr[AW-1:0] : d_addr_q;
  assign d_rd   = (d_state_q == StIdle) ? Data_rd : d_rd_q;
  assign d_din  = (d_state_q == StIdle) ? Data_din : d_din_q;

  always_comb begin
    i_state_d = i_state_q;
    i_cnt_d   = i_cnt_q;
    i_capture = 1'b0;
    i_access  = 1'b0;
    unique case (i_state_q)
      StIdle: begin
        if (instrmem_rd) begin
          i_capture = 1'b1;
          if (FetchWaits == 4'd0) begin
            i_state_d = StDone;
            i_access  = 1'b1;
          end else begin
            i_cnt_d   = FetchWaits;
            i_state_d = StWait;
          end
        end
      end
      StWait: begin
        i_cnt_d = i_cnt_q - 4'd1;
        if (!instrmem_rd) begin
          i_state_d = StIdle;
        end else if (i_cnt_q == 4'd1) begin
          i_state_d = StDone;
          i_access  = 1'b1;
        end
      end
      StDone:  i_state_d = StIdle;
      default: i_state_d = StIdle;
    endcase
  end

  always_comb begin
    d_state_d = d_state_q;
    d_cnt_d   = d_cnt_q;
    d_capture = 1'b0;
    d_access  = 1'b0;
    unique case (d_state_q)
      StIdle: begin
        if (data_req) begin
          d_capture = 1'b1;
          if (DataWaits == 4'd0) begin
            d_state_d = StDone;
            d_access  = 1'b1;
          end else begin
            d_cnt_d   = DataWaits;
            d_state_d = StWait;
          end
        end
      end
      StWait: begin
        d_cnt_d = d_cnt_q - 4'd1;
        if (!data_req) begin
          d_state_d = StIdle;
        end else if (d_cnt_q == 4'd1) begin
          d_state_d = StDone;
          d_access  = 1'b1;
        end
      end
      StDone:  d_state_d = StIdle;
      default: d_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      i_state_q        <= StIdle;
      i_cnt_q          <= 4'd0;
      i_addr_q         <= '0;
      instr_q          <= 16'h0000;
      complete_instr_q <= 1'b0;
    end else begin
      i_state_q        <= i_state_d;
      i_cnt_q          <= i_cnt_d;
      complete_instr_q <= i_access;
      if (i_capture) i_addr_q <= pc[AW-1:0];
      if (i_access)  instr_q  <= mem[i_addr];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      d_state_q       <= StIdle;
      d_cnt_q         <= 4'd0;
      d_addr_q        <= '0;
      d_rd_q          <= 1'b0;
      d_din_q         <= 16'h0000;
      data_q          <= 16'h0000;
      complete_data_q <= 1'b0;
    end else begin
      d_state_q       <= d_state_d;
      d_cnt_q         <= d_cnt_d;
      complete_data_q <= d_access;
      if (d_capture) begin
        d_addr_q <= Data_addr[AW-1:0];
        d_rd_q   <= Data_rd;
        d_din_q  <= Data_din;
      end
      if (d_access && d_rd) data_q <= mem[d_addr];
    end
  end

  // The preload write is issued last so it overrides a same-address data write.
  always_ff @(posedge clock) begin
    if (d_access && !d_rd && !reset) mem[d_addr] <= d_din;
    if (load_en) mem[load_addr[AW-1:0]] <= load_data;
  end

  assign Instr_dout     = instr_q;
  assign complete_instr = complete_instr_q;
  assign Data_dout      = data_q;
  assign complete_data  = complete_data_q;

endmodule

// File: tb/tb_lc3_mem_responder.sv
// Bench for lc3_mem_responder: two instances (zero waits and T_FETCH=5/T_DATA=3) checked
// by per-port scoreboards that hold expected value and due cycle for each completion.
module tb_lc3_mem_responder;

  typedef struct {
    logic [15:0] val;
    int          due;
    string       name;
  } exp_t;

  typedef struct {
    logic        rd;
    logic [15:0] addr;
    logic [15:0] din;
    logic [15:0] exp;
  } vec_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset       [2];
  logic [15:0] pc          [2];
  logic        instrmem_rd [2];
  logic        data_req    [2];
  logic        data_rd     [2];
  logic [15:0] data_addr   [2];
  logic [15:0] data_din    [2];
  logic        load_en     [2];
  logic [15:0] load_addr   [2];
  logic [15:0] load_data   [2];
  wire  [15:0] instr_dout  [2];
  wire         complete_instr [2];
  wire  [15:0] data_dout   [2];
  wire         complete_data  [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    lc3_mem_responder #(
      .AW      (16),
      .T_FETCH (g == 0 ? 0 : 5),
      .T_DATA  (g == 0 ? 0 : 3)
    ) u_dut (
      .clock          (clock),
      .reset          (reset[g]),
      .pc             (pc[g]),
      .instrmem_rd    (instrmem_rd[g]),
      .Instr_dout     (instr_dout[g]),
      .complete_instr (complete_instr[g]),
      .data_req       (data_req[g]),
      .Data_rd        (data_rd[g]),
      .Data_addr      (data_addr[g]),
      .Data_din       (data_din[g]),
      .Data_dout      (data_dout[g]),
      .complete_data  (complete_data[g]),
      .load_en        (load_en[g]),
      .load_addr      (load_addr[g]),
      .load_data      (load_data[g])
    );
  end

  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  logic [15:0] last_dout [2];
  exp_t        iq0[$], iq1[$], dq0[$], dq1[$];
  exp_t        mon_e;
  vec_t        vecs [9];

  always @(posedge clock) cyc++;

  function automatic int tf(input int d);
    return (d == 0) ? 0 : 5;
  endfunction

  function automatic int td(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  function automatic void check(input string name, input logic [15:0] act,
                                input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endfunction

  function automatic void check_exp(input exp_t e, input logic [15:0] act);
    checks++;
    if (act !== e.val || cyc != e.due) begin
      errors++;
      $display("FAIL %s: got %h at cycle %0d, expected %h at cycle %0d",
               e.name, act, cyc, e.val, e.due);
    end
  endfunction

  function automatic void unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s: strobe at cycle %0d, expected none", name, cyc);
  endfunction

  always @(negedge clock) begin
    if (complete_instr[0]) begin
      if (iq0.size() == 0) unexpected("d0 instr");
      else begin mon_e = iq0.pop_front(); check_exp(mon_e, instr_dout[0]); end
    end
    if (complete_instr[1]) begin
      if (iq1.size() == 0) unexpected("d1 instr");
      else begin mon_e = iq1.pop_front(); check_exp(mon_e, instr_dout[1]); end
    end
    if (complete_data[0]) begin
      if (dq0.size() == 0) unexpected("d0 data");
      else begin mon_e = dq0.pop_front(); check_exp(mon_e, data_dout[0]); end
    end
    if (complete_data[1]) begin
      if (dq1.size() == 0) unexpected("d1 data");
      else begin mon_e = dq1.pop_front(); check_exp(mon_e, data_dout[1]); end
    end
  end

  task automatic push_i(input int d, input exp_t e);
    if (d == 0) iq0.push_back(e);
    else        iq1.push_back(e);
  endtask

  task automatic push_d(input int d, input exp_t e);
    if (d == 0) dq0.push_back(e);
    else        dq1.push_back(e);
  endtask

  task automatic load(input int d, input logic [15:0] a, input logic [15:0] v);
    load_en[d]   = 1'b1;
    load_addr[d] = a;
    load_data[d] = v;
    @(posedge clock);
    #1;
    load_en[d] = 1'b0;
  endtask

  // Request held until the access edge; pc switched to alt after capture.
  task automatic ireq(input int d, input logic [15:0] addr, input logic [15:0] alt,
                      input logic [15:0] exp);
    exp_t e;
    pc[d]          = addr;
    instrmem_rd[d] = 1'b1;
    e.val  = exp;
    e.due  = cyc + 1 + tf(d);
    e.name = $sformatf("d%0d instr %h", d, addr);
    push_i(d, e);
    @(posedge clock);
    #1;
    pc[d] = alt;
    repeat (tf(d)) @(posedge clock);
    #1;
    instrmem_rd[d] = 1'b0;
    @(posedge clock);
    #1;
  endtask

  // Address/data scrambled after capture to confirm the latched values are used.
  task automatic dreq(input int d, input logic rd, input logic [15:0] addr,
                      input logic [15:0] din, input logic [15:0] exp_rd);
    exp_t e;
    data_req[d]  = 1'b1;
    data_rd[d]   = rd;
    data_addr[d] = addr;
    data_din[d]  = din;
    if (rd) begin
      e.val        = exp_rd;
      last_dout[d] = exp_rd;
    end else begin
      e.val = last_dout[d];
    end
    e.due  = cyc + 1 + td(d);
    e.name = $sformatf("d%0d data %s %h", d, rd ? "rd" : "wr", addr);
    push_d(d, e);
    @(posedge clock);
    #1;
    data_addr[d] = addr ^ 16'h00ff;
    data_din[d]  = ~din;
    repeat (td(d)) @(posedge clock);
    #1;
    data_req[d] = 1'b0;
    @(posedge clock);
    #1;
  endtask

  initial begin
    vecs[0] = '{1'b0, 16'h0010, 16'hA5A5, 16'h0000};
    vecs[1] = '{1'b0, 16'h0011, 16'h5A5A, 16'h0000};
    vecs[2] = '{1'b1, 16'h0010, 16'h0000, 16'hA5A5};
    vecs[3] = '{1'b1, 16'h0011, 16'h0000, 16'h5A5A};
    vecs[4] = '{1'b0, 16'h0010, 16'hFFFF, 16'h0000};
    vecs[5] = '{1'b1, 16'h0010, 16'h0000, 16'hFFFF};
    vecs[6] = '{1'b1, 16'hFFFF, 16'h0000, 16'h0F0F};
    vecs[7] = '{1'b0, 16'h0000, 16'h0001, 16'h0000};
    vecs[8] = '{1'b1, 16'h0000, 16'h0000, 16'h0001};

    for (int d = 0; d < 2; d++) begin
      reset[d] = 1'b1;     pc[d] = 16'h0;        instrmem_rd[d] = 1'b0;
      data_req[d] = 1'b0;  data_rd[d] = 1'b0;    data_addr[d] = 16'h0;
      data_din[d] = 16'h0; load_en[d] = 1'b0;    load_addr[d] = 16'h0;
      load_data[d] = 16'h0; last_dout[d] = 16'h0;
    end
    // Preload while reset is held.
    load_en[1] = 1'b1; load_addr[1] = 16'h3001; load_data[1] = 16'h4242;
    repeat (2) @(posedge clock);
    #1;
    load_en[1] = 1'b0;
    @(negedge clock);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("d%0d reset Instr_dout", d), instr_dout[d], 16'h0000);
      check($sformatf("d%0d reset Data_dout", d), data_dout[d], 16'h0000);
      check($sformatf("d%0d reset complete_instr", d), {15'b0, complete_instr[d]}, 16'h0);
      check($sformatf("d%0d reset complete_data", d), {15'b0, complete_data[d]}, 16'h0);
    end
    @(posedge clock);
    #1;
    reset[0] = 1'b0;
    reset[1] = 1'b0;

    for (int d = 0; d < 2; d++) begin
      load(d, 16'h3000, 16'h1234);
      load(d, 16'h3010, 16'h7777);
      load(d, 16'h3002, 16'hAAAA);
      load(d, 16'h4001, 16'h0000);
      load(d, 16'h4002, 16'h0102);
      load(d, 16'hFFFF, 16'h0F0F);
    end

    // Fetch held high with zero waits: completions two cycles apart.
    pc[0] = 16'h3000;
    instrmem_rd[0] = 1'b1;
    push_i(0, '{16'h1234, cyc + 1, "d0 held fetch #1"});
    push_i(0, '{16'h1234, cyc + 3, "d0 held fetch #2"});
    repeat (4) @(posedge clock);
    #1;
    instrmem_rd[0] = 1'b0;

    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 9; i++) begin
        dreq(d, vecs[i].rd, vecs[i].addr, vecs[i].din, vecs[i].exp);
      end
    end

    dreq(1, 1'b0, 16'h4000, 16'hBEEF, 16'h0000);
    dreq(1, 1'b1, 16'h4000, 16'h0000, 16'hBEEF);

    // Write dropped during WAIT must not commit.
    data_req[1]  = 1'b1;
    data_rd[1]   = 1'b0;
    data_addr[1] = 16'h4001;
    data_din[1]  = 16'h1234;
    repeat (2) @(posedge clock);
    #1;
    data_req[1] = 1'b0;
    @(posedge clock);
    #1;
    dreq(1, 1'b1, 16'h4001, 16'h0000, 16'h0000);

    // Same-edge write and fetch: fetch sees the old word.
    fork
      ireq(0, 16'h3002, 16'h3002, 16'hAAAA);
      dreq(0, 1'b0, 16'h3002, 16'h5555, 16'h0000);
    join
    ireq(0, 16'h3002, 16'h3002, 16'h5555);

    // Same-edge preload and data write: preload wins.
    fork
      dreq(0, 1'b0, 16'h3100, 16'h1111, 16'h0000);
      load(0, 16'h3100, 16'h2222);
    join
    dreq(0, 1'b1, 16'h3100, 16'h0000, 16'h2222);

    ireq(1, 16'h3001, 16'h3001, 16'h4242);
    ireq(1, 16'h3000, 16'h3010, 16'h1234);
    dreq(1, 1'b1, 16'h4000, 16'h0000, 16'hBEEF);

    // Reset while both dut1 ports sit in WAIT.
    pc[1]          = 16'h3000;
    instrmem_rd[1] = 1'b1;
    data_req[1]    = 1'b1;
    data_rd[1]     = 1'b0;
    data_addr[1]   = 16'h4002;
    data_din[1]    = 16'h9999;
    repeat (3) @(posedge clock);
    #1;
    reset[1] = 1'b1;
    @(posedge clock);
    #1;
    reset[1]       = 1'b0;
    data_req[1]    = 1'b0;
    instrmem_rd[1] = 1'b0;
    last_dout[1]   = 16'h0000;
    fork
      ireq(1, 16'h3010, 16'h3010, 16'h7777);
      begin
        @(negedge clock);
        check("d1 post-reset Instr_dout", instr_dout[1], 16'h0000);
        check("d1 post-reset Data_dout", data_dout[1], 16'h0000);
        check("d1 post-reset complete_instr", {15'b0, complete_instr[1]}, 16'h0);
        check("d1 post-reset complete_data", {15'b0, complete_data[1]}, 16'h0);
      end
    join
    dreq(1, 1'b1, 16'h4002, 16'h0000, 16'h0102);

    repeat (20) @(posedge clock);
    #1;
    check("d0 instr pending", 16'(iq0.size()), 16'h0);
    check("d1 instr pending", 16'(iq1.size()), 16'h0);
    check("d0 data pending", 16'(dq0.size()), 16'h0);
    check("d1 data pending", 16'(dq1.size()), 16'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
